// File: rtl/pipe_pkg.sv
// Shared types for the ID-stage hazard/forwarding tracker: stage entry, select width, bubble.
package pipe_pkg;

    // Entry register field is sized for the widest supported index; narrower REG_W zero-extends.
    localparam int REG_W_MAX = 8;

    typedef struct packed {
        logic                 valid;
        logic                 wr_en;
        logic [REG_W_MAX-1:0] wr_reg;
        logic                 is_load;
    } stage_t;

    localparam stage_t BUBBLE = '0;

    function automatic int fsel_w(input int stages);
        return $clog2(stages + 1);
    endfunction

endpackage

// File: rtl/pipe_match.sv
// Youngest-match search for one ID source across the tracked stages.
module pipe_match
    import pipe_pkg::*;
#(
    parameter int STAGES = 3,
    parameter int REG_W  = 5,
    parameter int FSEL_W = 2
) (
    input  logic                    used,
    input  logic [REG_W-1:0]        src,
    input  stage_t [STAGES-1:0]     stg,
    output logic [FSEL_W-1:0]       idx,
    output logic                    ld
);

    // Walk oldest to youngest so the youngest hit overwrites older ones.
    always_comb begin
        idx = '0;
        ld  = 1'b0;
        for (int k = STAGES; k >= 1; k--) begin
            if (used && src != '0 && stg[k-1].valid && stg[k-1].wr_en &&
                stg[k-1].wr_reg == REG_W_MAX'(src)) begin
                idx = FSEL_W'(k);
                ld  = stg[k-1].is_load;
            end
        end
    end

endmodule

// File: rtl/pipe_track.sv
// In-order pipeline scoreboard: tracks EX..WB destinations, picks forwarding sources and load-use stalls.
module pipe_track
    import pipe_pkg::*;
#(
    parameter int STAGES   = 3,
    parameter int REG_W    = 5,
    parameter int SRC_N    = 2,
    parameter int LOAD_LAT = 2,
    localparam int FSEL_W  = fsel_w(STAGES)
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          id_valid,
    input  logic                          id_wr_en,
    input  logic [REG_W-1:0]              id_wr_reg,
    input  logic                          id_is_load,
    input  logic [SRC_N-1:0][REG_W-1:0]   id_src_reg,
    input  logic [SRC_N-1:0]              id_src_used,
    input  logic                          flush_id,
    input  logic                          flush_all,
    input  logic                          stall_ext,
    output logic                          stall,
    output logic [SRC_N-1:0][FSEL_W-1:0]  fwd_sel,
    output logic [STAGES-1:0]             stg_valid,
    output logic [STAGES-1:0][REG_W-1:0]  stg_wr_reg,
    output logic [15:0]                   hazard_cnt
);

    stage_t [STAGES-1:0] stg;
    stage_t              id_e;
    logic [SRC_N-1:0]    src_ld;
    logic [SRC_N-1:0]    src_hz;
    logic                hazard;

    for (genvar s = 0; s < SRC_N; s++) begin : g_src
        pipe_match #(.STAGES(STAGES), .REG_W(REG_W), .FSEL_W(FSEL_W)) u_match (
            .used (id_src_used[s]),
            .src  (id_src_reg[s]),
            .stg  (stg),
            .idx  (fwd_sel[s]),
            .ld   (src_ld[s])
        );
        // Load data becomes forwardable from stage LOAD_LAT onward.
        assign src_hz[s] = src_ld[s] && fwd_sel[s] != '0 && int'(fwd_sel[s]) < LOAD_LAT;
    end

    assign hazard = id_valid && |src_hz;
    assign stall  = hazard || stall_ext;

    always_comb begin
        id_e         = BUBBLE;
        id_e.valid   = 1'b1;
        id_e.wr_en   = id_wr_en;
        id_e.wr_reg  = REG_W_MAX'(id_wr_reg);
        id_e.is_load = id_is_load;
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_out
        assign stg_valid[k]  = stg[k].valid;
        assign stg_wr_reg[k] = stg[k].wr_reg[REG_W-1:0];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stg <= '0;
        end else if (flush_all) begin
            stg <= '0;
        end else if (!stall_ext) begin
            for (int k = STAGES - 1; k >= 1; k--)
                stg[k] <= stg[k-1];
            stg[0] <= (id_valid && !hazard && !flush_id) ? id_e : BUBBLE;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            hazard_cnt <= '0;
        else if (hazard && !stall_ext && hazard_cnt != 16'hFFFF)
            hazard_cnt <= hazard_cnt + 16'd1;
    end

endmodule

// File: tb/tb_pipe_track.sv
// Directed bench for pipe_track with hand-computed expectations at default parameters.
module tb_pipe_track;

    localparam int STAGES = 3;
    localparam int REG_W  = 5;
    localparam int SRC_N  = 2;
    localparam int FSEL_W = 2;

    logic                         clk = 1'b0;
    logic                         reset;
    logic                         id_valid, id_wr_en, id_is_load;
    logic [REG_W-1:0]             id_wr_reg;
    logic [SRC_N-1:0][REG_W-1:0]  id_src_reg;
    logic [SRC_N-1:0]             id_src_used;
    logic                         flush_id, flush_all, stall_ext;
    logic                         stall;
    logic [SRC_N-1:0][FSEL_W-1:0] fwd_sel;
    logic [STAGES-1:0]            stg_valid;
    logic [STAGES-1:0][REG_W-1:0] stg_wr_reg;
    logic [15:0]                  hazard_cnt;

    int vectors = 0;
    int errs    = 0;

    pipe_track #(.STAGES(STAGES), .REG_W(REG_W), .SRC_N(SRC_N), .LOAD_LAT(2)) dut (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_wr_en(id_wr_en),
        .id_wr_reg(id_wr_reg), .id_is_load(id_is_load), .id_src_reg(id_src_reg),
        .id_src_used(id_src_used), .flush_id(flush_id), .flush_all(flush_all),
        .stall_ext(stall_ext), .stall(stall), .fwd_sel(fwd_sel), .stg_valid(stg_valid),
        .stg_wr_reg(stg_wr_reg), .hazard_cnt(hazard_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic id_set(input logic v, input logic we, input logic [REG_W-1:0] wr,
                          input logic ld, input logic [REG_W-1:0] s0, input logic [REG_W-1:0] s1,
                          input logic [SRC_N-1:0] used);
        id_valid = v; id_wr_en = we; id_wr_reg = wr; id_is_load = ld;
        id_src_reg[0] = s0; id_src_reg[1] = s1; id_src_used = used;
    endtask

    task automatic drain();
        id_set(0, 0, 0, 0, 0, 0, 2'b00);
        repeat (3) tick();
    endtask

    initial begin
        reset = 1'b0; flush_id = 0; flush_all = 0; stall_ext = 1'b1;
        id_set(1, 0, 0, 0, 5'd8, 5'd0, 2'b01);
        #12;
        chk("rst_valid", 32'(stg_valid), 0);
        chk("rst_cnt", 32'(hazard_cnt), 0);
        chk("rst_stall_ext", 32'(stall), 1);
        chk("rst_fwd", 32'(fwd_sel), 0);
        stall_ext = 0; settle();
        chk("rst_stall", 32'(stall), 0);
        reset = 1'b1;

        // Scenario 1: ALU result forwarded from EX
        id_set(1, 1, 5'd8, 0, 0, 0, 2'b00);
        tick();
        id_set(1, 0, 0, 0, 5'd8, 0, 2'b01); settle();
        chk("s1_fwd", 32'(fwd_sel[0]), 1);
        chk("s1_stall", 32'(stall), 0);
        chk("s1_valid", 32'(stg_valid), 3'b001);
        chk("s1_wreg", 32'(stg_wr_reg[0]), 8);
        drain();
        chk("s1_drain", 32'(stg_valid), 0);

        // Scenario 2: load-use, one bubble then forward from stage 2
        id_set(1, 1, 5'd8, 1, 0, 0, 2'b00);
        tick();
        id_set(1, 1, 5'd3, 0, 5'd8, 0, 2'b01); settle();
        chk("s2_stall", 32'(stall), 1);
        tick();
        chk("s2_release", 32'(stall), 0);
        chk("s2_fwd", 32'(fwd_sel[0]), 2);
        chk("s2_cnt", 32'(hazard_cnt), 1);
        chk("s2_bubble", 32'(stg_valid), 3'b010);
        tick();
        chk("s2_issue", 32'(stg_valid), 3'b101);
        chk("s2_wreg", 32'(stg_wr_reg[0]), 3);
        drain();

        // Scenario 3: r0 never forwards
        id_set(1, 1, 5'd0, 0, 0, 0, 2'b00);
        tick();
        id_set(1, 0, 0, 0, 5'd0, 0, 2'b01); settle();
        chk("s3_fwd", 32'(fwd_sel[0]), 0);
        chk("s3_stall", 32'(stall), 0);
        drain();

        // Scenario 4: younger ALU write shadows older load
        id_set(1, 1, 5'd9, 1, 0, 0, 2'b00);
        tick();
        id_set(1, 1, 5'd9, 0, 0, 0, 2'b00);
        tick();
        id_set(1, 0, 0, 0, 5'd9, 5'd9, 2'b10); settle();
        chk("s4_fwd1", 32'(fwd_sel[1]), 1);
        chk("s4_unused", 32'(fwd_sel[0]), 0);
        chk("s4_stall", 32'(stall), 0);
        drain();
        chk("s4_cnt", 32'(hazard_cnt), 1);

        // Scenario 5: external stall freezes a pending load-use
        id_set(1, 1, 5'd8, 1, 0, 0, 2'b00);
        tick();
        id_set(1, 0, 0, 0, 5'd8, 0, 2'b01);
        stall_ext = 1; settle();
        chk("s5_stall", 32'(stall), 1);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("s5_frz_valid", 32'(stg_valid), 3'b001);
            chk("s5_frz_cnt", 32'(hazard_cnt), 1);
        end
        chk("s5_frz_wreg", 32'(stg_wr_reg[0]), 8);
        stall_ext = 0; settle();
        chk("s5_hazard", 32'(stall), 1);
        tick();
        chk("s5_cnt", 32'(hazard_cnt), 2);
        chk("s5_fwd", 32'(fwd_sel[0]), 2);
        chk("s5_release", 32'(stall), 0);
        tick();
        chk("s5_wb_fwd", 32'(fwd_sel[0]), 3);
        chk("s5_wb_stall", 32'(stall), 0);

        // Scenario 6: flush_all beats stall_ext, flush_id with hazard, async reset
        id_set(1, 1, 5'd5, 0, 0, 0, 2'b00);
        stall_ext = 1; flush_all = 1;
        tick();
        chk("s6_flush", 32'(stg_valid), 0);
        chk("s6_flush_cnt", 32'(hazard_cnt), 2);
        stall_ext = 0; flush_all = 0;
        tick();
        id_set(1, 1, 5'd6, 1, 0, 0, 2'b00);
        tick();
        id_set(1, 1, 5'd7, 0, 5'd6, 0, 2'b01);
        flush_id = 1; settle();
        chk("s6_fid_stall", 32'(stall), 1);
        tick();
        flush_id = 0;
        chk("s6_fid_bubble", 32'(stg_valid), 3'b110);
        chk("s6_fid_cnt", 32'(hazard_cnt), 3);
        #2 reset = 1'b0;
        #1;
        chk("s6_rst_valid", 32'(stg_valid), 0);
        chk("s6_rst_cnt", 32'(hazard_cnt), 0);
        chk("s6_rst_wreg", 32'(stg_wr_reg), 0);
        #3 reset = 1'b1;
        tick();
        chk("s6_after", 32'(stg_valid), 3'b001);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule
